// File: rtl/node_rx.sv
// Receive side of the single-wire node bus: deframes, address-filters and CRC-4 checks frames.
// Define BROADCAST_EN to make destination all-ones match on every node.
module node_rx #(
    parameter int          ADDR_W   = 4,
    parameter int          DATA_W   = 64,
    parameter logic [3:0]  CRC_INIT = 4'h0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] src_addr,
    output logic [1:0]        mod_out,
    output logic              valid,
    output logic              crc_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int HDR_W = 2 * ADDR_W + 2;

    typedef enum logic [2:0] {IDLE, HDR, PAY, CRC, STOP} state_t;

    state_t            state;
    state_t            state_next;
    logic [6:0]        cnt;
    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] shreg;
    logic [3:0]        crc;
    logic [3:0]        crc_rx;
    logic [3:0]        crc_upd;
    logic [1:0]        mod_next;
    logic [6:0]        pay_len_m1;
    logic [ADDR_W-1:0] dest;
    logic              last;
    logic              match;
    logic              crc_fb;

    assign last     = (cnt == 7'd0);
    assign dest     = hdr[HDR_W-1 -: ADDR_W];
    assign crc_fb   = crc[3] ^ bus;
    assign crc_upd  = {crc[2:0], 1'b0} ^ (crc_fb ? 4'b0011 : 4'b0000);
    // The mod field's low bit is still on the wire during the last header cycle.
    assign mod_next = {hdr[0], bus};

`ifdef BROADCAST_EN
    assign match = (dest == addr) || (dest == {ADDR_W{1'b1}});
`else
    assign match = (dest == addr);
`endif

    always_comb begin
        pay_len_m1 = 7'd63;
        case (mod_next)
            2'b00:   pay_len_m1 = 7'd7;
            2'b01:   pay_len_m1 = 7'd15;
            2'b10:   pay_len_m1 = 7'd31;
            default: pay_len_m1 = 7'd63;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!bus) state_next = HDR;
            HDR:     if (last) state_next = PAY;
            PAY:     if (last) state_next = CRC;
            CRC:     if (last) state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= 7'd0;
            hdr       <= '0;
            shreg     <= '0;
            crc       <= CRC_INIT;
            crc_rx    <= 4'h0;
            data_out  <= '0;
            src_addr  <= '0;
            mod_out   <= 2'b00;
            valid     <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus) begin
                        cnt    <= 7'(HDR_W - 1);
                        hdr    <= '0;
                        shreg  <= '0;
                        crc    <= CRC_INIT;
                        crc_rx <= 4'h0;
                    end
                end
                HDR: begin
                    hdr <= {hdr[HDR_W-2:0], bus};
                    crc <= crc_upd;
                    cnt <= last ? pay_len_m1 : cnt - 7'd1;
                end
                PAY: begin
                    shreg <= {shreg[DATA_W-2:0], bus};
                    crc   <= crc_upd;
                    cnt   <= last ? 7'd3 : cnt - 7'd1;
                end
                CRC: begin
                    crc_rx <= {crc_rx[2:0], bus};
                    cnt    <= last ? 7'd0 : cnt - 7'd1;
                end
                STOP: begin
                    // A bad stop bit overrides any address or CRC outcome.
                    if (!bus) begin
                        frame_err <= 1'b1;
                    end else if (match) begin
                        if (crc_rx == crc) begin
                            valid    <= 1'b1;
                            data_out <= shreg;
                            src_addr <= hdr[2 +: ADDR_W];
                            mod_out  <= hdr[1:0];
                        end else begin
                            crc_err <= 1'b1;
                        end
                    end
                end
                default: cnt <= 7'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_node_rx.sv
// Scoreboard bench for node_rx: directed frames push expected pulses, a monitor pops and compares.
module tb_node_rx;

    logic        clock = 1'b0;
    logic        reset;
    logic        bus;
    logic [3:0]  addr;
    logic [63:0] data_out;
    logic [3:0]  src_addr;
    logic [1:0]  mod_out;
    logic        valid;
    logic        crc_err;
    logic        frame_err;
    logic        busy;

    typedef struct {
        int          kind;
        logic [63:0] data;
        logic [3:0]  src;
        logic [1:0]  mod;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_data;
    logic [3:0]  last_src;
    logic [1:0]  last_mod;

    node_rx dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .addr(addr),
        .data_out(data_out),
        .src_addr(src_addr),
        .mod_out(mod_out),
        .valid(valid),
        .crc_err(crc_err),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] crcStep(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clock);
            bus = 1'b1;
        end
    endtask

    // Builds a full frame bit by bit, registers the expected outcome, then drives it.
    task automatic applyStimulus(input logic [3:0] dest, input logic [3:0] src, input logic [1:0] mod,
                                 input logic [63:0] payload, input logic flip_crc, input logic stop_bit,
                                 input int abort_at);
        logic       bits[$];
        int         n;
        int         kind;
        logic [3:0] c;
        logic       hit;
        exp_t       e;
        n = (mod == 2'b00) ? 8 : (mod == 2'b01) ? 16 : (mod == 2'b10) ? 32 : 64;
        bits.push_back(1'b0);
        for (int i = 3; i >= 0; i--) bits.push_back(dest[i]);
        for (int i = 3; i >= 0; i--) bits.push_back(src[i]);
        for (int i = 1; i >= 0; i--) bits.push_back(mod[i]);
        for (int i = n - 1; i >= 0; i--) bits.push_back(payload[i]);
        c = 4'h0;
        for (int i = 1; i < bits.size(); i++) c = crcStep(c, bits[i]);
        if (flip_crc) c[0] = ~c[0];
        for (int i = 3; i >= 0; i--) bits.push_back(c[i]);
        bits.push_back(stop_bit);

        hit = (dest == addr);
`ifdef BROADCAST_EN
        if (dest == 4'hF) hit = 1'b1;
`endif
        kind = -1;
        if (!stop_bit) kind = 2;
        else if (hit) kind = flip_crc ? 1 : 0;
        if (kind == 0) begin
            last_data = payload & ((n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1));
            last_src  = src;
            last_mod  = mod;
        end

        for (int i = 0; i < bits.size(); i++) begin
            if (abort_at >= 0 && i == abort_at) break;
            @(negedge clock);
            bus = bits[i];
            if (i == 0 && abort_at < 0 && kind >= 0) begin
                // Stop bit is sampled bits.size() edges from now; the pulse is seen after that edge.
                e.kind = kind;
                e.data = last_data;
                e.src  = last_src;
                e.mod  = last_mod;
                e.cyc  = cyc + bits.size();
                sb.push_back(e);
            end
            if (i == bits.size() - 1) checkOutput("busy_during_stop", {63'd0, busy}, 64'd1);
        end
        if (abort_at < 0) begin
            @(posedge clock);
            #1;
            checkOutput("busy_after_stop", {63'd0, busy}, 64'd0);
        end
    endtask

    always @(negedge clock) begin
        if (valid || crc_err || frame_err) begin
            if (sb.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("[TB] FAIL unexpected_pulse: got valid=%b crc_err=%b frame_err=%b, expected none",
                         valid, crc_err, frame_err);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("pulse_valid", {63'd0, valid}, {63'd0, mon_e.kind == 0});
                checkOutput("pulse_crc_err", {63'd0, crc_err}, {63'd0, mon_e.kind == 1});
                checkOutput("pulse_frame_err", {63'd0, frame_err}, {63'd0, mon_e.kind == 2});
                checkOutput("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
                checkOutput("data_out", data_out, mon_e.data);
                checkOutput("src_addr", {60'd0, src_addr}, {60'd0, mon_e.src});
                checkOutput("mod_out", {62'd0, mod_out}, {62'd0, mon_e.mod});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        bus       = 1'b1;
        addr      = 4'h1;
        last_data = 64'd0;
        last_src  = 4'd0;
        last_mod  = 2'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idleCycles(20);
        checkOutput("reset_data_out", data_out, 64'd0);
        checkOutput("reset_src_addr", {60'd0, src_addr}, 64'd0);
        checkOutput("reset_mod_out", {62'd0, mod_out}, 64'd0);
        checkOutput("reset_pulses", {61'd0, valid, crc_err, frame_err}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);

        applyStimulus(4'h1, 4'h0, 2'b00, 64'hA5, 1'b0, 1'b1, -1);
        idleCycles(3);
        applyStimulus(4'h1, 4'h0, 2'b11, 64'h0123456789ABCDEF, 1'b1, 1'b1, -1);
        idleCycles(3);
        applyStimulus(4'h2, 4'h0, 2'b01, 64'h0, 1'b0, 1'b1, -1);
        applyStimulus(4'h1, 4'h3, 2'b01, 64'hBEEF, 1'b0, 1'b1, -1);
        idleCycles(3);
        applyStimulus(4'h1, 4'h4, 2'b00, 64'h77, 1'b0, 1'b0, -1);
        idleCycles(2);
        applyStimulus(4'h1, 4'h5, 2'b10, 64'hDEADBEEF, 1'b0, 1'b1, -1);
        applyStimulus(4'h1, 4'h6, 2'b00, 64'h3C, 1'b0, 1'b1, -1);
        idleCycles(3);
        applyStimulus(4'hF, 4'h7, 2'b00, 64'h5A, 1'b0, 1'b1, -1);
        idleCycles(3);

        // Abort after start, header and four payload bits.
        applyStimulus(4'h1, 4'h8, 2'b01, 64'h1234, 1'b0, 1'b1, 15);
        @(negedge clock);
        checkOutput("busy_mid_payload", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        bus   = 1'b1;
        #1;
        checkOutput("abort_data_out", data_out, 64'd0);
        checkOutput("abort_src_addr", {60'd0, src_addr}, 64'd0);
        checkOutput("abort_mod_out", {62'd0, mod_out}, 64'd0);
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        last_data = 64'd0;
        last_src  = 4'd0;
        last_mod  = 2'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        idleCycles(2);
        applyStimulus(4'h1, 4'h2, 2'b00, 64'h81, 1'b0, 1'b1, -1);
        idleCycles(5);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
